// File: rtl/instr_queue_dual.sv
// Two-wide instruction queue between fetch and decode.
// Each cycle it accepts 0-2 enqueues and 0-2 dequeues, and it can be flushed on a branch redirect.
module instr_queue_dual #(
    parameter int IWIDTH = 32,
    parameter int DEPTH  = 8,
    parameter int CWIDTH = $clog2(DEPTH) + 1
) (
    input  logic              iq_i_clk,
    input  logic              iq_i_rst,
    input  logic              iq_i_flush,
    input  logic [1:0]        iq_i_wr_en,
    input  logic [IWIDTH-1:0] iq_i_instr0,
    input  logic [IWIDTH-1:0] iq_i_instr1,
    input  logic [1:0]        iq_i_rd_cnt,
    output logic [IWIDTH-1:0] iq_o_instr0,
    output logic [IWIDTH-1:0] iq_o_instr1,
    output logic              iq_o_valid0,
    output logic              iq_o_valid1,
    output logic              iq_o_check_queue,
    output logic              iq_o_ready,
    output logic [CWIDTH-1:0] iq_o_count,
    output logic              iq_o_overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [IWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [1:0]        nw, nw_acc, rc, nr;
    logic [CWIDTH-1:0] free;
    logic              accept, we;
    logic [IWIDTH-1:0] slot0_data;
    logic [PW-1:0]     head1, tail1;

    always_comb begin
        nw         = {1'b0, iq_i_wr_en[0]} + {1'b0, iq_i_wr_en[1]};
        free       = CWIDTH'(DEPTH) - count_q;
        accept     = free >= CWIDTH'(nw);
        nw_acc     = accept ? nw : 2'd0;
        rc         = (iq_i_rd_cnt == 2'd3) ? 2'd2 : iq_i_rd_cnt;
        // Never dequeue more than is held, so an empty read is a no-op.
        nr         = (count_q < CWIDTH'(rc)) ? count_q[1:0] : rc;
        head_d     = head_q + PW'(nr);
        tail_d     = tail_q + PW'(nw_acc);
        count_d    = count_q + CWIDTH'(nw_acc) - CWIDTH'(nr);
        ovf_d      = !accept;
        we         = accept && !iq_i_rst && !iq_i_flush;
        slot0_data = iq_i_wr_en[0] ? iq_i_instr0 : iq_i_instr1;
        head1      = head_q + PW'(1);
        tail1      = tail_q + PW'(1);
    end

    always_ff @(posedge iq_i_clk) begin
        if (iq_i_rst || iq_i_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is never cleared; valid gating hides stale contents.
    always_ff @(posedge iq_i_clk) begin
        if (we && nw != 2'd0) mem_q[tail_q] <= slot0_data;
        if (we && nw == 2'd2) mem_q[tail1]  <= iq_i_instr1;
    end

    assign iq_o_valid0      = count_q != '0;
    assign iq_o_valid1      = count_q >= CWIDTH'(2);
    assign iq_o_check_queue = iq_o_valid0;
    assign iq_o_instr0      = iq_o_valid0 ? mem_q[head_q] : '0;
    assign iq_o_instr1      = iq_o_valid1 ? mem_q[head1] : '0;
    assign iq_o_ready       = free >= CWIDTH'(2);
    assign iq_o_count       = count_q;
    assign iq_o_overflow    = ovf_q;

    a_count_max: assert property (@(posedge iq_i_clk)
        count_q <= CWIDTH'(DEPTH));
    a_no_underflow: assert property (@(posedge iq_i_clk)
        disable iff (iq_i_rst || iq_i_flush)
        count_q + CWIDTH'(nw_acc) >= CWIDTH'(nr));

endmodule

// File: tb/tb_instr_queue_dual.sv
// Directed bench for instr_queue_dual: a vector table plus a
// hand-written wrap-around streaming sequence.
module tb_instr_queue_dual;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [1:0]  wr_en, rd_cnt;
    logic [31:0] in0, in1;
    logic [31:0] o_i0, o_i1;
    logic        o_v0, o_v1, o_cq, o_rdy, o_ovf;
    logic [3:0]  o_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    instr_queue_dual dut (
        .iq_i_clk        (clk),
        .iq_i_rst        (rst),
        .iq_i_flush      (flush),
        .iq_i_wr_en      (wr_en),
        .iq_i_instr0     (in0),
        .iq_i_instr1     (in1),
        .iq_i_rd_cnt     (rd_cnt),
        .iq_o_instr0     (o_i0),
        .iq_o_instr1     (o_i1),
        .iq_o_valid0     (o_v0),
        .iq_o_valid1     (o_v1),
        .iq_o_check_queue(o_cq),
        .iq_o_ready      (o_rdy),
        .iq_o_count      (o_cnt),
        .iq_o_overflow   (o_ovf)
    );

    typedef struct packed {
        logic [31:0] i0;
        logic [31:0] i1;
        logic        v0;
        logic        v1;
        logic        cq;
        logic        rdy;
        logic [3:0]  cnt;
        logic        ovf;
    } out_t;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [1:0]  wr;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rd;
        out_t        exp;
    } vec_t;

    vec_t tbl[$];

    function automatic out_t e(input logic [31:0] i0, input logic [31:0] i1,
                               input logic v0, input logic v1, input logic rdy,
                               input logic [3:0] cnt, input logic ovf);
        out_t r;
        r = '{i0: i0, i1: i1, v0: v0, v1: v1, cq: v0, rdy: rdy, cnt: cnt, ovf: ovf};
        return r;
    endfunction

    function automatic vec_t v(input logic r, input logic f, input logic [1:0] w,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] rd, input out_t x);
        vec_t t;
        t.rst = r; t.flush = f; t.wr = w; t.a = a; t.b = b; t.rd = rd; t.exp = x;
        return t;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = '{i0: o_i0, i1: o_i1, v0: o_v0, v1: o_v1, cq: o_cq,
                rdy: o_rdy, cnt: o_cnt, ovf: o_ovf};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got i0=%h i1=%h v0=%b v1=%b cq=%b rdy=%b cnt=%0d ovf=%b, want i0=%h i1=%h v0=%b v1=%b cq=%b rdy=%b cnt=%0d ovf=%b",
                name, got.i0, got.i1, got.v0, got.v1, got.cq, got.rdy, got.cnt, got.ovf,
                exp.i0, exp.i1, exp.v0, exp.v1, exp.cq, exp.rdy, exp.cnt, exp.ovf);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] b, input logic [1:0] rd);
        rst = r; flush = f; wr_en = w; in0 = a; in1 = b; rd_cnt = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 2'b00; rd_cnt = 2'd0; in0 = '0; in1 = '0;

        // reset, 2-lane write, partial read, underflow clamp
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 0, e(0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'hA0, 32'hA1, 0, e(32'hA0, 32'hA1, 1, 1, 1, 2, 0)));
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 1, e(32'hA1, 0, 1, 0, 1, 1, 0)));
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 2, e(0, 0, 0, 0, 1, 0, 0)));
        // fill, overflow, drain (rd_cnt=3 acts as 2)
        tbl.push_back(v(0, 0, 2'b11, 32'h10, 32'h11, 0, e(32'h10, 32'h11, 1, 1, 1, 2, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'h12, 32'h13, 0, e(32'h10, 32'h11, 1, 1, 1, 4, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'h14, 32'h15, 0, e(32'h10, 32'h11, 1, 1, 1, 6, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'h16, 32'h17, 0, e(32'h10, 32'h11, 1, 1, 0, 8, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'hFF, 32'hFE, 0, e(32'h10, 32'h11, 1, 1, 0, 8, 1)));
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 0, e(32'h10, 32'h11, 1, 1, 0, 8, 0)));
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 2, e(32'h12, 32'h13, 1, 1, 1, 6, 0)));
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 2, e(32'h14, 32'h15, 1, 1, 1, 4, 0)));
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 3, e(32'h16, 32'h17, 1, 1, 1, 2, 0)));
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 2, e(0, 0, 0, 0, 1, 0, 0)));
        // lane1-only write, then read 2 with count 1
        tbl.push_back(v(0, 0, 2'b10, 32'hDEAD, 32'h55, 0, e(32'h55, 0, 1, 0, 1, 1, 0)));
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 2, e(0, 0, 0, 0, 1, 0, 0)));
        // full with same-cycle read: write still rejected on pre-edge count
        tbl.push_back(v(0, 0, 2'b11, 32'h20, 32'h21, 0, e(32'h20, 32'h21, 1, 1, 1, 2, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'h22, 32'h23, 0, e(32'h20, 32'h21, 1, 1, 1, 4, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'h24, 32'h25, 0, e(32'h20, 32'h21, 1, 1, 1, 6, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'h26, 32'h27, 0, e(32'h20, 32'h21, 1, 1, 0, 8, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'h30, 32'h31, 2, e(32'h22, 32'h23, 1, 1, 1, 6, 1)));
        tbl.push_back(v(0, 0, 2'b01, 32'h32, 32'hBAD, 0, e(32'h22, 32'h23, 1, 1, 0, 7, 0)));
        tbl.push_back(v(0, 0, 2'b01, 32'h33, 32'hBAD, 0, e(32'h22, 32'h23, 1, 1, 0, 8, 0)));
        tbl.push_back(v(0, 0, 2'b01, 32'h34, 32'hBAD, 0, e(32'h22, 32'h23, 1, 1, 0, 8, 1)));
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 3, e(32'h24, 32'h25, 1, 1, 1, 6, 0)));
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 1, e(32'h25, 32'h26, 1, 1, 1, 5, 0)));
        // flush with count 5 and same-cycle write + read
        tbl.push_back(v(0, 1, 2'b11, 32'h40, 32'h41, 2, e(0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'h42, 32'h43, 0, e(32'h42, 32'h43, 1, 1, 1, 2, 0)));
        // reset mid-operation at count 6
        tbl.push_back(v(0, 0, 2'b11, 32'h44, 32'h45, 0, e(32'h42, 32'h43, 1, 1, 1, 4, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'h46, 32'h47, 0, e(32'h42, 32'h43, 1, 1, 1, 6, 0)));
        tbl.push_back(v(1, 0, 2'b11, 32'h48, 32'h49, 2, e(0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0, 0, 2'b01, 32'h77, 32'hBAD, 0, e(32'h77, 0, 1, 0, 1, 1, 0)));
        tbl.push_back(v(0, 0, 2'b11, 32'h78, 32'h79, 1, e(32'h78, 32'h79, 1, 1, 1, 2, 0)));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].wr, tbl[i].a, tbl[i].b, tbl[i].rd);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // streaming 2-in/2-out across several pointer wraps
        drive(1, 0, 2'b00, 0, 0, 0);
        check("stream_reset", e(0, 0, 0, 0, 1, 0, 0));
        drive(0, 0, 2'b11, 32'h100, 32'h101, 0);
        check("stream_prime", e(32'h100, 32'h101, 1, 1, 1, 2, 0));
        for (int k = 1; k <= 20; k++) begin
            logic [31:0] base;
            base = 32'h100 + 32'(2 * k);
            drive(0, 0, 2'b11, base, base + 1, 2);
            check($sformatf("stream%0d", k), e(base, base + 1, 1, 1, 1, 2, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/instr_queue_dual.md
Name: instr_queue_dual

Overview:
- Two-wide instruction buffer between instruction memory fetch and the decode-side queue/memory select mux.
- Captures fetched instructions when decode stalls.
- Presents the two oldest entries in order, with a non-empty flag that drives the mux select (queue path over memory path).
- Supports 0/1/2 enqueues and 0/1/2 dequeues per cycle, plus a flush for branch redirect.

Parameters:
- IWIDTH, 32, instruction width in bits (matches header `IWIDTH).
- DEPTH, 8, number of entries; power of two, >= 4.
- CWIDTH, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- iq_i_clk  input  1  clock, rising edge.
- iq_i_rst  input  1  synchronous, active-high reset.
- iq_i_flush  input  1  empty the queue (branch redirect).
- iq_i_wr_en  input  2  per-lane enqueue valid; bit0 = lane0 (older), bit1 = lane1.
- iq_i_instr0  input  IWIDTH  lane0 instruction.
- iq_i_instr1  input  IWIDTH  lane1 instruction.
- iq_i_rd_cnt  input  2  entries consumed this cycle (0..2).
- iq_o_instr0  output  IWIDTH  head entry (oldest).
- iq_o_instr1  output  IWIDTH  head+1 entry.
- iq_o_valid0  output  1  iq_o_instr0 valid (count >= 1).
- iq_o_valid1  output  1  iq_o_instr1 valid (count >= 2).
- iq_o_check_queue  output  1  queue non-empty; equals iq_o_valid0; feeds mux select.
- iq_o_ready  output  1  free slots >= 2; upstream may present a two-lane write.
- iq_o_count  output  CWIDTH  current occupancy.
- iq_o_overflow  output  1  one-cycle pulse: a write was dropped in the previous cycle.

Behaviour:
- Clock and reset: single clock iq_i_clk. iq_i_rst is synchronous, active-high.
- Reset/flush state: head = tail = count = 0; overflow = 0. Storage array is not cleared.
- Reset effect on outputs (from the first cycle after the reset edge): valid0/valid1/check_queue = 0, instr0/instr1 = 0, ready = 1, count = 0, overflow = 0.
- Priority: rst > flush > normal operation. Flush takes effect at the next edge and discards any same-cycle writes and reads.
- Read path (combinational from registered state):
  - instr0 = mem[head], instr1 = mem[(head+1) mod DEPTH].
  - Each output is forced to 0 when its valid bit is low.
  - Dequeued entries leave the outputs at the next edge.
- Write latency: an entry enqueued at edge N is visible on the outputs after edge N. There is no same-cycle bypass from write to output.
- Write count: nw = popcount(iq_i_wr_en).
- Write packing: valid lanes are packed in order, lane0 before lane1.
  - wr_en = 2'b10 writes lane1's data into a single slot at tail.
  - wr_en = 2'b11 writes lane0 at tail, lane1 at tail+1.
- Write acceptance:
  - Accepted iff (DEPTH - count) >= nw, using the pre-edge count (dequeues in the same cycle do not free space for writes).
  - Acceptance is all-or-nothing: a rejected write stores nothing, moves no pointer, and sets overflow = 1 for the next cycle only.
- Dequeue: nr = min(iq_i_rd_cnt clamped to 2, count), using the pre-edge count.
  - Dequeue on empty is a no-op.
  - rd_cnt = 3 is treated as 2.
- Update at each non-reset, non-flush edge:
  - head += nr, tail += nw_acc, both mod DEPTH.
  - count = count + nw_acc - nr.
  - nw_acc = nw if the write is accepted, else 0.
- Simultaneous write and read in the same cycle are both legal, including on a full queue with nr = 2 and nw = 0.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer comparison.
- Ready and count:
  - ready = (DEPTH - count) >= 2.
  - count never exceeds DEPTH and never goes negative. Both are assertion-worthy invariants.
- Reset mid-operation: all in-flight state is discarded. There is no partial drain.

Test Plan:
- Reset, then 2-lane write of 0xA0,0xA1 in one cycle; next cycle -> instr0 = 0xA0, instr1 = 0xA1, valid0 = valid1 = check_queue = 1, count = 2. With rd_cnt = 1 -> next cycle instr0 = 0xA1, valid1 = 0, count = 1.
- Fill DEPTH = 8 via four 2-lane writes (0x10..0x17) -> count = 8, ready = 0. Fifth write of 0xFF,0xFE -> dropped, overflow = 1 for exactly one cycle, count stays 8. Drain 2 per cycle -> outputs 0x10/0x11, 0x12/0x13, ... then empty, check_queue = 0.
- Wrap-around: run 20 cycles of simultaneous 2-write/2-read with incrementing data starting 0x100 -> outputs strictly sequential, no gaps or duplicates, count constant at 2 after priming.
- wr_en = 2'b10 with instr1 = 0x55 on empty queue -> next cycle instr0 = 0x55, count = 1, valid1 = 0. rd_cnt = 2 with count = 1 -> count = 0, no underflow.
- Flush with count = 5 and same-cycle 2-lane write plus rd_cnt = 2 -> next cycle count = 0, check_queue = 0, ready = 1, write discarded.
- Assert iq_i_rst for one cycle with count = 6 -> next cycle all outputs at reset values; a subsequent write of 0x77 appears at instr0 with count = 1.
